mem_bus_bridge: RTL and testbench
=================================

// Module: mem_bus_bridge
// PURPOSE
//  Downstream companion of the CPU core's external bus. Demultiplexes the core's shared address/data bus:
//  - address is latched on ALE;
//  - address is decoded into an on-chip RAM region and a memory-mapped IO region;
//  - wait states are inserted on nWait;
//  - read data is returned on Data_in.
//  Sits between the core's bus pins and the RAM macro / peripheral fabric.
// PARAMETERS
//  ADDR_W      16        width of latched address and of both data buses
//  RAM_WAIT    1         wait cycles per RAM access (0..15)
//  IO_BASE     16'hFC00  addresses >= IO_BASE decode to IO; below go to RAM
//  IO_TIMEOUT  15        max cycles to wait for IoReady before bus error (1..15)
// PORTS
//  Clock      in   1       system clock, all logic on rising edge
//  nReset     in   1       synchronous, active-low reset
//  Data_out   in   16      core bus: address while ALE=1, write data otherwise
//  ALE        in   1       address latch enable from core
//  nME        in   1       memory cycle enable from core, active low
//  RnW        in   1       1 = read, 0 = write; sampled with nME
//  Data_in    out  16      read data to core, registered
//  nWait      out  1       0 = stall core, registered
//  MemAddr    out  16      RAM address (= latched address)
//  MemWData   out  16      RAM write data
//  MemRData   in   16      RAM read data, valid RAM_WAIT cycles after MemRe
//  MemRe      out  1       RAM read strobe, one-cycle pulse
//  MemWe      out  1       RAM write strobe, one-cycle pulse
//  IoAddr     out  16      IO address (= latched address)
//  IoWData    out  16      IO write data
//  IoRData    in   16      IO read data, valid when IoReady=1
//  IoRe       out  1       IO read request, held until IoReady or timeout
//  IoWe       out  1       IO write request, held until IoReady or timeout
//  IoReady    in   1       peripheral completion
//  BusErr     out  1       one-cycle pulse on IO timeout
// BEHAVIOUR
//  Reset (nReset=0 at an edge):
//   - state=IDLE, nWait=1, Data_in=0, strobes=0, BusErr=0, AddrReg=0, counter=0.
//   - Reset mid-access aborts the access with no completion strobe.
//  States: IDLE, ADDR, RAM_ACC, IO_ACC, HOLD.
//  IDLE:
//   - ALE=1 -> AddrReg<=Data_out; go ADDR.
//  ADDR:
//   - ALE=1 again -> re-latch AddrReg and stay in ADDR.
//   - nME=0 -> decode AddrReg and sample RnW; nWait<=0 in the same edge.
//   - RAM read: MemRe pulse; cnt<=RAM_WAIT; go RAM_ACC.
//   - RAM write: MemWe pulse, MemWData<=Data_out; cnt<=RAM_WAIT; go RAM_ACC.
//   - IO access: IoRe or IoWe<=1, IoWData<=Data_out; cnt<=IO_TIMEOUT; go IO_ACC.
//  RAM_ACC:
//   - cnt!=0 -> cnt--.
//   - cnt==0 -> (read) Data_in<=MemRData; nWait<=1; go HOLD.
//   - RAM_WAIT=0: nWait is low for exactly one cycle.
//  IO_ACC:
//   - IoReady=1 -> (read) Data_in<=IoRData; drop IoRe/IoWe; nWait<=1; go HOLD.
//   - else cnt==0 -> drop IoRe/IoWe; Data_in<=16'hFFFF on read; BusErr pulse; nWait<=1; go HOLD.
//   - IoReady on the same cycle as cnt==0: IoReady wins, no BusErr.
//  HOLD:
//   - Data_in is held stable.
//   - nME=1 -> go IDLE; if ALE=1 in the same cycle, latch and go ADDR (back-to-back access).
//  Abort: nME=1 while in RAM_ACC/IO_ACC -> drop all strobes, nWait<=1, go IDLE; Data_in unchanged.
//  Decode compares the full 16-bit address, unsigned. 16'hFBFF -> RAM; 16'hFC00 -> IO; 16'hFFFF -> IO.
//  MemAddr and IoAddr are both driven from AddrReg at all times. Only strobes are region-gated.
// STRUCTURE
//  Shared package bus_pkg:
//   - bus_state_t enum (IDLE, ADDR, RAM_ACC, IO_ACC, HOLD);
//   - BUS_ERR_DATA=16'hFFFF;
//   - default IO_BASE;
//   - region_t enum {REG_RAM, REG_IO}.
//  Sub-module bus_wait_timer: 4-bit loadable down-counter with load/enable and zero flag.
//  It is shared by the RAM wait and IO timeout paths.
// TESTING
//  1. RAM read: ALE with 16'h0100, then nME=0, RnW=1, MemRData=16'hBEEF, RAM_WAIT=1
//     -> MemRe one cycle, nWait low 2 cycles, Data_in=16'hBEEF.
//  2. RAM write: addr 16'h0200, data 16'h1234
//     -> single MemWe pulse with MemAddr=16'h0200, MemWData=16'h1234; Data_in unchanged.
//  3. IO read: addr 16'hFC04, IoReady after 3 cycles, IoRData=16'h00A5
//     -> IoRe high 3 cycles, nWait released the next edge, Data_in=16'h00A5, BusErr=0.
//  4. IO timeout: addr 16'hFFFE, IoReady never
//     -> nWait low IO_TIMEOUT+1 cycles, BusErr one pulse, Data_in=16'hFFFF.
//  5. Boundary and abort:
//     - decode 16'hFBFF vs 16'hFC00 -> RAM vs IO respectively;
//     - nME=1 mid IO_ACC -> IoRe drops, state IDLE, nWait=1 the next cycle.
//  6. Back-to-back and reset:
//     - ALE with nME rising in HOLD -> new address latched with no idle cycle;
//     - nReset=0 mid RAM_ACC -> all outputs at reset values the next edge.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the core bus bridge
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RAM_ACC = 3'd2,
    IO_ACC  = 3'd3,
    HOLD    = 3'd4
  } bus_state_t;

  typedef enum logic {
    REG_RAM = 1'b0,
    REG_IO  = 1'b1
  } region_t;

  localparam logic [15:0] BUS_ERR_DATA    = 16'hFFFF;
  localparam logic [15:0] DEFAULT_IO_BASE = 16'hFC00;

  // Unsigned full-width compare; everything at or above io_base is IO.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input logic [15:0] io_base);
    return (addr >= io_base) ? REG_IO : REG_RAM;
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// rtl/mem_bus_bridge_if.sv - core bus, RAM and IO signal bundle
interface mem_bus_bridge_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] Data_out;
  logic              ALE;
  logic              nME;
  logic              RnW;
  logic [ADDR_W-1:0] Data_in;
  logic              nWait;
  logic [ADDR_W-1:0] MemAddr;
  logic [ADDR_W-1:0] MemWData;
  logic [ADDR_W-1:0] MemRData;
  logic              MemRe;
  logic              MemWe;
  logic [ADDR_W-1:0] IoAddr;
  logic [ADDR_W-1:0] IoWData;
  logic [ADDR_W-1:0] IoRData;
  logic              IoRe;
  logic              IoWe;
  logic              IoReady;
  logic              BusErr;

  // master: core plus RAM/IO fabric around the bridge
  modport master (
    output Data_out, ALE, nME, RnW, MemRData, IoRData, IoReady,
    input  Data_in, nWait, MemAddr, MemWData, MemRe, MemWe,
           IoAddr, IoWData, IoRe, IoWe, BusErr
  );

  modport slave (
    input  Data_out, ALE, nME, RnW, MemRData, IoRData, IoReady,
    output Data_in, nWait, MemAddr, MemWData, MemRe, MemWe,
           IoAddr, IoWData, IoRe, IoWe, BusErr
  );
endinterface

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - 4-bit loadable down-counter with zero flag
module bus_wait_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - demultiplexes the core address/data bus onto RAM and IO
module mem_bus_bridge
  import bus_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int unsigned RAM_WAIT   = 1,
  parameter logic [15:0] IO_BASE    = DEFAULT_IO_BASE,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input logic         Clock,
  input logic         nReset,
  mem_bus_bridge_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_ADDR    = ADDR;
  localparam logic [2:0] ST_RAM_ACC = RAM_ACC;
  localparam logic [2:0] ST_IO_ACC  = IO_ACC;
  localparam logic [2:0] ST_HOLD    = HOLD;

  localparam logic [3:0]        RAM_WAIT_L   = 4'(RAM_WAIT);
  localparam logic [3:0]        IO_TIMEOUT_L = 4'(IO_TIMEOUT);
  localparam logic [ADDR_W-1:0] ERR_DATA     = ADDR_W'(BUS_ERR_DATA);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] io_wdata_q, io_wdata_d;
  logic              nwait_q, nwait_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              io_re_q, io_re_d;
  logic              io_we_q, io_we_d;
  logic              bus_err_q, bus_err_d;
  logic              rd_q, rd_d;

  logic       tmr_load;
  logic [3:0] tmr_load_val;
  logic       tmr_en;
  logic       tmr_zero;
  region_t    region;

  assign region = decode_region(16'(addr_q), IO_BASE);

  bus_wait_timer u_timer (
    .clk_i      (Clock),
    .rst_ni     (nReset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    mem_wdata_d  = mem_wdata_q;
    io_wdata_d   = io_wdata_q;
    nwait_d      = nwait_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    io_re_d      = io_re_q;
    io_we_d      = io_we_q;
    bus_err_d    = 1'b0;
    rd_d         = rd_q;
    tmr_load     = 1'b0;
    tmr_load_val = RAM_WAIT_L;
    tmr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ALE) begin
          addr_d  = bus.Data_out;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (bus.ALE) begin
          addr_d = bus.Data_out;
        end else if (!bus.nME) begin
          nwait_d  = 1'b0;
          rd_d     = bus.RnW;
          tmr_load = 1'b1;
          if (region == REG_IO) begin
            io_re_d      = bus.RnW;
            io_we_d      = !bus.RnW;
            io_wdata_d   = bus.Data_out;
            tmr_load_val = IO_TIMEOUT_L;
            state_d      = ST_IO_ACC;
          end else begin
            mem_re_d = bus.RnW;
            mem_we_d = !bus.RnW;
            if (!bus.RnW) begin
              mem_wdata_d = bus.Data_out;
            end
            state_d = ST_RAM_ACC;
          end
        end
      end

      ST_RAM_ACC: begin
        // Abort takes priority over completion; read data is left untouched.
        if (bus.nME) begin
          nwait_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          if (rd_q) begin
            rdata_d = bus.MemRData;
          end
          nwait_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_IO_ACC: begin
        if (bus.nME) begin
          io_re_d = 1'b0;
          io_we_d = 1'b0;
          nwait_d = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.IoReady) begin
          if (rd_q) begin
            rdata_d = bus.IoRData;
          end
          io_re_d = 1'b0;
          io_we_d = 1'b0;
          nwait_d = 1'b1;
          state_d = ST_HOLD;
        end else if (tmr_zero) begin
          if (rd_q) begin
            rdata_d = ERR_DATA;
          end
          io_re_d   = 1'b0;
          io_we_d   = 1'b0;
          bus_err_d = 1'b1;
          nwait_d   = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_HOLD: begin
        if (bus.nME) begin
          if (bus.ALE) begin
            addr_d  = bus.Data_out;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        io_re_d = 1'b0;
        io_we_d = 1'b0;
        nwait_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      io_wdata_q  <= '0;
      nwait_q     <= 1'b1;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      io_re_q     <= 1'b0;
      io_we_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      io_wdata_q  <= io_wdata_d;
      nwait_q     <= nwait_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      io_re_q     <= io_re_d;
      io_we_q     <= io_we_d;
      bus_err_q   <= bus_err_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.Data_in  = rdata_q;
  assign bus.nWait    = nwait_q;
  assign bus.MemAddr  = addr_q;
  assign bus.MemWData = mem_wdata_q;
  assign bus.MemRe    = mem_re_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.IoAddr   = addr_q;
  assign bus.IoWData  = io_wdata_q;
  assign bus.IoRe     = io_re_q;
  assign bus.IoWe     = io_we_q;
  assign bus.BusErr   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - directed vector bench for mem_bus_bridge
module tb_mem_bus_bridge;

  logic clk;
  logic nreset;
  int   tests;
  int   fails;

  mem_bus_bridge_if #(.ADDR_W(16)) bus ();

  mem_bus_bridge #(
    .ADDR_W     (16),
    .RAM_WAIT   (1),
    .IO_BASE    (16'hFC00),
    .IO_TIMEOUT (15)
  ) dut (
    .Clock  (clk),
    .nReset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        rnw;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ready_after;
    int          exp_wait;
    int          exp_mre;
    int          exp_mwe;
    int          exp_ire;
    int          exp_iwe;
    int          exp_err;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n_wait, n_mre, n_mwe, n_ire, n_iwe, n_err;
    bit done;
    logic [15:0] strobe_addr, strobe_wdata;
    n_wait = 0; n_mre = 0; n_mwe = 0; n_ire = 0; n_iwe = 0; n_err = 0;
    done = 1'b0;
    strobe_addr = 16'h0;
    strobe_wdata = 16'h0;
    bus.ALE = 1'b1;
    bus.Data_out = v.addr;
    tick();
    bus.ALE = 1'b0;
    bus.nME = 1'b0;
    bus.RnW = v.rnw;
    bus.Data_out = v.wdata;
    bus.MemRData = v.rdata;
    bus.IoRData = v.rdata;
    bus.IoReady = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      tick();
      if (!bus.nWait) n_wait++;
      if (bus.MemRe) begin n_mre++; strobe_addr = bus.MemAddr; end
      if (bus.MemWe) begin n_mwe++; strobe_addr = bus.MemAddr; strobe_wdata = bus.MemWData; end
      if (bus.IoRe) begin n_ire++; strobe_addr = bus.IoAddr; end
      if (bus.IoWe) begin n_iwe++; strobe_addr = bus.IoAddr; strobe_wdata = bus.IoWData; end
      if (bus.BusErr) n_err++;
      if (bus.nWait) done = 1'b1;
      if (k == v.ready_after) bus.IoReady = 1'b1;
    end
    chk({v.name, " done"}, 32'(done), 32'd1);
    chk({v.name, " wait"}, 32'(n_wait), 32'(v.exp_wait));
    chk({v.name, " MemRe"}, 32'(n_mre), 32'(v.exp_mre));
    chk({v.name, " MemWe"}, 32'(n_mwe), 32'(v.exp_mwe));
    chk({v.name, " IoRe"}, 32'(n_ire), 32'(v.exp_ire));
    chk({v.name, " IoWe"}, 32'(n_iwe), 32'(v.exp_iwe));
    chk({v.name, " BusErr"}, 32'(n_err), 32'(v.exp_err));
    chk({v.name, " strobe addr"}, 32'(strobe_addr), 32'(v.addr));
    if (!v.rnw) chk({v.name, " wdata"}, 32'(strobe_wdata), 32'(v.wdata));
    chk({v.name, " Data_in"}, 32'(bus.Data_in), 32'(v.exp_data));
    bus.nME = 1'b1;
    bus.IoReady = 1'b0;
    tick();
    chk({v.name, " hold"}, 32'(bus.Data_in), 32'(v.exp_data));
    chk({v.name, " release"}, {30'd0, bus.nWait, bus.BusErr}, 32'd2);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //          name     addr      rnw wdata     rdata     rdy wt mre mwe ire iwe err data
    vecs[0] = '{"ramrd",  16'h0100, 1'b1, 16'h0000, 16'hBEEF, -1, 2, 1, 0, 0, 0, 0, 16'hBEEF};
    vecs[1] = '{"ramwr",  16'h0200, 1'b0, 16'h1234, 16'h0000, -1, 2, 0, 1, 0, 0, 0, 16'hBEEF};
    vecs[2] = '{"iord",   16'hFC04, 1'b1, 16'h0000, 16'h00A5,  3, 3, 0, 0, 3, 0, 0, 16'h00A5};
    vecs[3] = '{"iotmo",  16'hFFFE, 1'b1, 16'h0000, 16'h0000, -1, 16, 0, 0, 16, 0, 1, 16'hFFFF};
    vecs[4] = '{"fbff",   16'hFBFF, 1'b1, 16'h0000, 16'h1111, -1, 2, 1, 0, 0, 0, 0, 16'h1111};
    vecs[5] = '{"fc00",   16'hFC00, 1'b0, 16'h5A5A, 16'h0000,  1, 1, 0, 0, 0, 1, 0, 16'h1111};
    vecs[6] = '{"tie",    16'hFFFF, 1'b1, 16'h0000, 16'h0042, 16, 16, 0, 0, 16, 0, 0, 16'h0042};
    vecs[7] = '{"iowtmo", 16'hFFFF, 1'b0, 16'hC3C3, 16'h0000, -1, 16, 0, 0, 0, 16, 1, 16'h0042};

    nreset = 1'b0;
    bus.Data_out = 16'h0;
    bus.ALE = 1'b0;
    bus.nME = 1'b1;
    bus.RnW = 1'b1;
    bus.MemRData = 16'h0;
    bus.IoRData = 16'h0;
    bus.IoReady = 1'b0;
    tick();
    tick();
    chk("reset nWait", 32'(bus.nWait), 32'd1);
    chk("reset Data_in", 32'(bus.Data_in), 32'd0);
    chk("reset strobes", {27'd0, bus.MemRe, bus.MemWe, bus.IoRe, bus.IoWe, bus.BusErr}, 32'd0);
    chk("reset addr", 32'(bus.MemAddr), 32'd0);
    nreset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort an IO read partway: request drops and the core is released next edge.
    bus.ALE = 1'b1;
    bus.Data_out = 16'hFC10;
    tick();
    bus.ALE = 1'b0;
    bus.nME = 1'b0;
    bus.RnW = 1'b1;
    tick();
    chk("abort IoRe on", 32'(bus.IoRe), 32'd1);
    tick();
    bus.nME = 1'b1;
    tick();
    chk("abort IoRe off", 32'(bus.IoRe), 32'd0);
    chk("abort nWait", 32'(bus.nWait), 32'd1);
    chk("abort BusErr", 32'(bus.BusErr), 32'd0);
    chk("abort Data_in", 32'(bus.Data_in), 32'h0042);
    tick();
    chk("abort idle", {30'd0, bus.IoRe, bus.nWait}, 32'd1);

    // Back-to-back: ALE together with nME rising in HOLD latches immediately.
    bus.ALE = 1'b1;
    bus.Data_out = 16'h0300;
    tick();
    bus.ALE = 1'b0;
    bus.nME = 1'b0;
    bus.MemRData = 16'h7777;
    tick();
    tick();
    tick();
    chk("b2b first data", 32'(bus.Data_in), 32'h7777);
    bus.nME = 1'b1;
    bus.ALE = 1'b1;
    bus.Data_out = 16'hFC20;
    tick();
    chk("b2b latch", 32'(bus.MemAddr), 32'hFC20);
    bus.ALE = 1'b0;
    bus.nME = 1'b0;
    bus.RnW = 1'b1;
    tick();
    chk("b2b IoRe", 32'(bus.IoRe), 32'd1);
    chk("b2b IoAddr", 32'(bus.IoAddr), 32'hFC20);
    bus.nME = 1'b1;
    tick();
    tick();

    // Reset in the middle of a RAM read.
    bus.ALE = 1'b1;
    bus.Data_out = 16'h0400;
    tick();
    bus.ALE = 1'b0;
    bus.nME = 1'b0;
    bus.MemRData = 16'h9999;
    tick();
    chk("mid MemRe", 32'(bus.MemRe), 32'd1);
    nreset = 1'b0;
    tick();
    chk("mid rst nWait", 32'(bus.nWait), 32'd1);
    chk("mid rst Data_in", 32'(bus.Data_in), 32'd0);
    chk("mid rst strobes", {27'd0, bus.MemRe, bus.MemWe, bus.IoRe, bus.IoWe, bus.BusErr}, 32'd0);
    chk("mid rst addr", 32'(bus.MemAddr), 32'd0);
    nreset = 1'b1;
    tick();
    tick();
    chk("post rst Data_in", 32'(bus.Data_in), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
